// File: rtl/si_tag_gen_pkg.sv
// Shared constants and types for the tag stream generator: register map, control bits,
// FSM states and tag type codes.
package si_tag_gen_pkg;

  // Word indices, decoded from adr[7:2]
  localparam logic [5:0] REG_PRESENCE  = 6'd0;
  localparam logic [5:0] REG_CONTROL   = 6'd1;
  localparam logic [5:0] REG_PKT_WORDS = 6'd2;
  localparam logic [5:0] REG_LAST_TAGS = 6'd3;
  localparam logic [5:0] REG_GAP       = 6'd4;
  localparam logic [5:0] REG_PKT_SENT  = 6'd5;
  localparam logic [5:0] REG_STATUS    = 6'd6;

  localparam int unsigned CTRL_ENABLE = 0;
  localparam int unsigned CTRL_START  = 1;
  localparam int unsigned CTRL_INJECT = 2;

  localparam logic [1:0] TAG_TYPE_NORMAL   = 2'b00;
  localparam logic [1:0] TAG_TYPE_OVERFLOW = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StGap
  } state_e;

endpackage

// File: rtl/wb_interface.sv
// Minimal Wishbone classic bus bundle used for the control/status port.
interface wb_interface;
  logic [31:0] adr;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        ack;

  modport slave (input adr, dat_i, we, cyc, stb, output dat_o, ack);
  modport master (output adr, dat_i, we, cyc, stb, input dat_o, ack);
endinterface

// File: rtl/si_tag_gen_regs.sv
// Wishbone register file for the tag stream generator: configuration, self-clearing
// start/inject requests, packets_sent counter and status.
module si_tag_gen_regs
  import si_tag_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] wb_adr,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_we,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  output logic        wb_ack,
  output logic [31:0] wb_dat_o,
  output logic        enable,
  output logic        start,
  output logic        inject,
  output logic [15:0] packet_words,
  output logic [7:0]  last_word_tags,
  output logic [15:0] gap_cycles,
  input  logic        start_clr,
  input  logic        inject_clr,
  input  logic        pkt_done,
  input  logic        busy
);

  logic        ack_q;
  logic [31:0] dat_o_q;
  logic        enable_q, start_q, inject_q;
  logic [15:0] pkt_words_q, gap_q;
  logic [7:0]  last_tags_q;
  logic [31:0] pkt_sent_q;
  logic [31:0] rdata;
  logic [5:0]  reg_idx;
  logic        wb_req, wr;
  logic        unused_bits;

  assign reg_idx     = wb_adr[7:2];
  // Suppress a request in the cycle it is acked so a held strobe yields one access
  assign wb_req      = wb_cyc && wb_stb && !ack_q;
  assign wr          = wb_req && wb_we;
  assign unused_bits = ^{wb_adr[31:8], wb_adr[1:0], wb_dat_i[31:16]};

  always_comb begin
    rdata = '0;
    case (reg_idx)
      REG_PRESENCE:  rdata = 32'd1;
      REG_CONTROL: begin
        rdata[CTRL_ENABLE] = enable_q;
        rdata[CTRL_INJECT] = inject_q;
      end
      REG_PKT_WORDS: rdata = {16'd0, pkt_words_q};
      REG_LAST_TAGS: rdata = {24'd0, last_tags_q};
      REG_GAP:       rdata = {16'd0, gap_q};
      REG_PKT_SENT:  rdata = pkt_sent_q;
      REG_STATUS:    rdata[0] = busy;
      default:       rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q       <= 1'b0;
      dat_o_q     <= '0;
      enable_q    <= 1'b0;
      start_q     <= 1'b0;
      inject_q    <= 1'b0;
      pkt_words_q <= '0;
      last_tags_q <= '0;
      gap_q       <= '0;
      pkt_sent_q  <= '0;
    end else begin
      ack_q   <= wb_req;
      dat_o_q <= wb_req ? rdata : '0;
      if (start_clr)  start_q <= 1'b0;
      if (inject_clr) inject_q <= 1'b0;
      if (pkt_done)   pkt_sent_q <= pkt_sent_q + 32'd1;
      // Later assignments win: a CPU write overrides a same-cycle clear or increment
      if (wr) begin
        case (reg_idx)
          REG_CONTROL: begin
            enable_q <= wb_dat_i[CTRL_ENABLE];
            if (wb_dat_i[CTRL_START])  start_q  <= 1'b1;
            if (wb_dat_i[CTRL_INJECT]) inject_q <= 1'b1;
          end
          REG_PKT_WORDS: pkt_words_q <= wb_dat_i[15:0];
          REG_LAST_TAGS: last_tags_q <= wb_dat_i[7:0];
          REG_GAP:       gap_q       <= wb_dat_i[15:0];
          REG_PKT_SENT:  pkt_sent_q  <= '0;
          default: ;
        endcase
      end
    end
  end

  assign wb_ack         = ack_q;
  assign wb_dat_o       = dat_o_q;
  assign enable         = enable_q;
  assign start          = start_q;
  assign inject         = inject_q;
  assign packet_words   = pkt_words_q;
  assign last_word_tags = last_tags_q;
  assign gap_cycles     = gap_q;

endmodule

// File: rtl/si_tag_stream_generator.sv
// Wishbone-controlled AXI-Stream tag packet source: sequencing FSM and word builder,
// with the register file in si_tag_gen_regs.
module si_tag_stream_generator
  import si_tag_gen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 128,
  parameter int unsigned KEEP_WIDTH    = (DATA_WIDTH + 7) / 8,
  parameter int unsigned TAGS_PER_WORD = DATA_WIDTH / 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  wb_interface.slave            wb
);

  localparam logic [7:0] TPW = 8'(TAGS_PER_WORD);

  logic        enable, start, inject;
  logic [15:0] cfg_words, cfg_gap;
  logic [7:0]  cfg_last;
  logic        start_clr, inject_clr, pkt_done, load_pkt;

  state_e      state_q, state_d;
  logic [15:0] word_cnt_q, word_cnt_d, words_q, words_d, gap_q, gap_d, gap_cnt_q, gap_cnt_d;
  logic [7:0]  last_tags_q, last_tags_d, kept;
  logic [29:0] tag_cnt_q, tag_cnt_d;
  logic        stall_q, ovf_hold_q, ovf_cur, hs, is_last;
  logic [15:0] norm_words;
  logic [7:0]  norm_last;

  si_tag_gen_regs u_regs (
    .clk            (clk),
    .rst_n          (rst_n),
    .wb_adr         (wb.adr),
    .wb_dat_i       (wb.dat_i),
    .wb_we          (wb.we),
    .wb_cyc         (wb.cyc),
    .wb_stb         (wb.stb),
    .wb_ack         (wb.ack),
    .wb_dat_o       (wb.dat_o),
    .enable         (enable),
    .start          (start),
    .inject         (inject),
    .packet_words   (cfg_words),
    .last_word_tags (cfg_last),
    .gap_cycles     (cfg_gap),
    .start_clr      (start_clr),
    .inject_clr     (inject_clr),
    .pkt_done       (pkt_done),
    .busy           (state_q != StIdle)
  );

  assign norm_words = (cfg_words == 16'd0) ? 16'd1 : cfg_words;
  assign norm_last  = (cfg_last == 8'd0 || cfg_last > TPW) ? TPW : cfg_last;
  assign is_last    = (word_cnt_q == words_q - 16'd1);
  assign kept       = is_last ? last_tags_q : TPW;
  assign hs         = m_axis_tvalid && m_axis_tready;
  // Freeze the overflow marking while a word is stalled so tdata stays stable
  assign ovf_cur    = stall_q ? ovf_hold_q : inject;
  assign inject_clr = hs && ovf_cur;

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    words_d     = words_q;
    last_tags_d = last_tags_q;
    gap_d       = gap_q;
    gap_cnt_d   = gap_cnt_q;
    tag_cnt_d   = tag_cnt_q;
    start_clr   = 1'b0;
    pkt_done    = 1'b0;
    load_pkt    = 1'b0;
    case (state_q)
      StIdle: begin
        if (enable || start) begin
          load_pkt  = 1'b1;
          start_clr = 1'b1;
        end
      end
      StSend: begin
        if (hs) begin
          word_cnt_d = word_cnt_q + 16'd1;
          tag_cnt_d  = tag_cnt_q + 30'(kept);
          if (is_last) begin
            pkt_done = 1'b1;
            if (gap_q != 16'd0) begin
              gap_cnt_d = gap_q;
              state_d   = StGap;
            end else if (enable) begin
              load_pkt = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
      StGap: begin
        gap_cnt_d = gap_cnt_q - 16'd1;
        if (gap_cnt_q == 16'd1) begin
          if (enable) load_pkt = 1'b1;
          else        state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Configuration is sampled only at packet start
    if (load_pkt) begin
      state_d     = StSend;
      word_cnt_d  = '0;
      words_d     = norm_words;
      last_tags_d = norm_last;
      gap_d       = cfg_gap;
    end
  end

  always_comb begin
    m_axis_tvalid = (state_q == StSend);
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    if (m_axis_tvalid) begin
      m_axis_tlast = is_last;
      for (int i = 0; i < TAGS_PER_WORD; i++) begin
        if (!is_last || i < int'(last_tags_q)) begin
          m_axis_tdata[32*i +: 32] = {TAG_TYPE_NORMAL, tag_cnt_q + 30'(i)};
          m_axis_tkeep[4*i +: 4]   = 4'hF;
        end
      end
      if (ovf_cur) m_axis_tdata[31:30] = TAG_TYPE_OVERFLOW;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      word_cnt_q  <= '0;
      words_q     <= '0;
      last_tags_q <= '0;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      tag_cnt_q   <= '0;
      stall_q     <= 1'b0;
      ovf_hold_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      words_q     <= words_d;
      last_tags_q <= last_tags_d;
      gap_q       <= gap_d;
      gap_cnt_q   <= gap_cnt_d;
      tag_cnt_q   <= tag_cnt_d;
      stall_q     <= m_axis_tvalid && !m_axis_tready;
      ovf_hold_q  <= ovf_cur;
    end
  end

endmodule

// File: tb/tb_si_tag_stream_generator.sv
// Directed self-checking bench for si_tag_stream_generator.
module tb_si_tag_stream_generator;

  logic         clk;
  logic         rst_n;
  logic         tvalid;
  logic [127:0] tdata;
  logic [15:0]  tkeep;
  logic         tlast;
  logic         tready;

  wb_interface wb_if ();

  si_tag_stream_generator dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .m_axis_tvalid (tvalid),
    .m_axis_tdata  (tdata),
    .m_axis_tkeep  (tkeep),
    .m_axis_tlast  (tlast),
    .m_axis_tready (tready),
    .wb            (wb_if)
  );

  int n_cmp = 0;
  int n_err = 0;
  int hs_cnt = 0;
  int ovf_cnt = 0;

  logic [127:0] w_data[16];
  logic [15:0]  w_keep[16];
  logic         w_last[16];
  int           n_words;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tvalid && tready) begin
      hs_cnt++;
      if (tdata[31:30] == 2'b10) ovf_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  task automatic wb_access(input logic [31:0] a, input logic [31:0] wd, input logic w,
                           output logic [31:0] rd);
    int n = 0;
    rd = '0;
    wb_if.adr = a;
    wb_if.dat_i = wd;
    wb_if.we = w;
    wb_if.cyc = 1'b1;
    wb_if.stb = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!wb_if.ack && n < 10);
    check("wb_ack", {127'd0, wb_if.ack}, 128'd1);
    rd = wb_if.dat_o;
    wb_if.cyc = 1'b0;
    wb_if.stb = 1'b0;
    wb_if.we = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    wb_access(a, d, 1'b1, dummy);
  endtask

  task automatic wb_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    wb_access(a, 32'd0, 1'b0, d);
    check(tag, {96'd0, d}, {96'd0, exp});
  endtask

  task automatic collect(input int max_cyc);
    bit done = 1'b0;
    n_words = 0;
    for (int c = 0; c < max_cyc && !done; c++) begin
      if (tvalid && n_words < 16) begin
        w_data[n_words] = tdata;
        w_keep[n_words] = tkeep;
        w_last[n_words] = tlast;
        n_words++;
        if (tlast) done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    check("collect_done", {127'd0, done}, 128'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic v[40];
    int f, bad, base;
    rst_n = 1'b0;
    tready = 1'b0;
    wb_if.adr = '0;
    wb_if.dat_i = '0;
    wb_if.we = 1'b0;
    wb_if.cyc = 1'b0;
    wb_if.stb = 1'b0;
    #1;
    check("rst_tvalid", {127'd0, tvalid}, 128'd0);
    check("rst_tdata", tdata, 128'd0);
    check("rst_tkeep", {112'd0, tkeep}, 128'd0);
    check("rst_tlast", {127'd0, tlast}, 128'd0);
    check("rst_ack", {127'd0, wb_if.ack}, 128'd0);
    check("rst_dat_o", {96'd0, wb_if.dat_o}, 128'd0);
    do_reset();

    // Single 3-word packet, 2 tags in the last word
    wb_check("presence", 32'h00, 32'd1);
    wb_write(32'h08, 32'd3);
    wb_write(32'h0C, 32'd2);
    tready = 1'b1;
    wb_write(32'h04, 32'h2);
    collect(20);
    check("p1_nwords", 128'(n_words), 128'd3);
    check("p1_keep0", {112'd0, w_keep[0]}, 128'hFFFF);
    check("p1_keep1", {112'd0, w_keep[1]}, 128'hFFFF);
    check("p1_keep2", {112'd0, w_keep[2]}, 128'h00FF);
    check("p1_last", {125'd0, w_last[0], w_last[1], w_last[2]}, 128'b001);
    check("p1_word0", w_data[0], 128'h00000003_00000002_00000001_00000000);
    check("p1_lane0_w1", {96'd0, w_data[1][31:0]}, 128'd4);
    check("p1_word2", w_data[2], 128'h00000000_00000000_00000009_00000008);
    wb_check("p1_sent", 32'h14, 32'd1);
    wb_check("p1_busy", 32'h18, 32'd0);
    wb_check("p1_ctrl", 32'h04, 32'd0);

    // Continuous single-word packets with a 5-cycle gap
    wb_write(32'h14, 32'hFFFF);
    wb_check("sent_clr", 32'h14, 32'd0);
    wb_write(32'h08, 32'd1);
    wb_write(32'h10, 32'd5);
    base = hs_cnt;
    wb_write(32'h04, 32'h1);
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      v[k] = tvalid;
      if (tvalid && !tlast) bad++;
      @(posedge clk);
      #1;
    end
    f = -1;
    for (int k = 0; k < 40; k++) if (v[k] && f < 0) f = k;
    check("cont_first", {127'd0, (f >= 0 && f <= 2)}, 128'd1);
    if (f < 0) f = 0;
    for (int k = 0; k < 30; k++) if (f + k < 40 && v[f+k] != (k % 6 == 0)) bad++;
    check("cont_period", 128'(bad), 128'd0);
    wb_write(32'h04, 32'h0);
    @(posedge clk);
    #1;
    bad = 0;
    for (int k = 0; k < 25; k++) begin
      if (tvalid) bad++;
      @(posedge clk);
      #1;
    end
    check("cont_stopped", 128'(bad), 128'd0);
    wb_check("cont_busy", 32'h18, 32'd0);
    wb_check("cont_sent", 32'h14, 32'(hs_cnt - base));

    // Stall mid-packet: 4 words, last-word tags default 0 -> full word
    do_reset();
    wb_write(32'h08, 32'd4);
    tready = 1'b0;
    wb_write(32'h04, 32'h2);
    for (int k = 0; k < 10 && !tvalid; k++) begin
      @(posedge clk);
      #1;
    end
    check("stall_valid", {127'd0, tvalid}, 128'd1);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (tdata !== 128'h00000003_00000002_00000001_00000000 || tkeep !== 16'hFFFF ||
          tlast !== 1'b0 || tvalid !== 1'b1) bad++;
      @(posedge clk);
      #1;
    end
    check("stall_stable", 128'(bad), 128'd0);
    tready = 1'b1;
    collect(20);
    check("stall_nwords", 128'(n_words), 128'd4);
    check("stall_lane0", {w_data[0][31:0], w_data[1][31:0], w_data[2][31:0], w_data[3][31:0]},
          {32'd0, 32'd4, 32'd8, 32'd12});
    check("stall_keep3", {112'd0, w_keep[3]}, 128'hFFFF);
    check("stall_last", {124'd0, w_last[0], w_last[1], w_last[2], w_last[3]}, 128'b0001);
    wb_check("stall_sent", 32'h14, 32'd1);

    // Overflow injection during a continuous run
    do_reset();
    wb_write(32'h08, 32'd2);
    tready = 1'b1;
    wb_write(32'h04, 32'h1);
    repeat (5) @(posedge clk);
    #1;
    base = ovf_cnt;
    wb_write(32'h04, 32'h5);
    repeat (10) @(posedge clk);
    #1;
    wb_check("ovf_ctrl", 32'h04, 32'h1);
    wb_write(32'h04, 32'h0);
    repeat (10) @(posedge clk);
    #1;
    check("ovf_count", 128'(ovf_cnt - base), 128'd1);

    // Asynchronous reset between clock edges mid-packet
    wb_write(32'h08, 32'd8);
    tready = 1'b0;
    wb_write(32'h04, 32'h2);
    repeat (3) @(posedge clk);
    check("arst_pre_valid", {127'd0, tvalid}, 128'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_tvalid", {127'd0, tvalid}, 128'd0);
    check("arst_tdata", tdata, 128'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wb_check("arst_words", 32'h08, 32'd0);
    wb_check("arst_ctrl", 32'h04, 32'd0);
    wb_check("arst_sent", 32'h14, 32'd0);
    wb_check("arst_status", 32'h18, 32'd0);
    wb_check("arst_presence", 32'h00, 32'd1);

    // Unmapped access, packet_words=0 and out-of-range last_word_tags
    wb_check("unmapped_rd", 32'h40, 32'd0);
    wb_write(32'h40, 32'hFFFF_FFFF);
    wb_check("unmapped_alias", 32'h08, 32'd0);
    wb_write(32'h0C, 32'd9);
    tready = 1'b1;
    wb_write(32'h04, 32'h2);
    collect(20);
    check("one_nwords", 128'(n_words), 128'd1);
    check("one_last", {127'd0, w_last[0]}, 128'd1);
    check("one_keep", {112'd0, w_keep[0]}, 128'hFFFF);
    check("one_data", w_data[0], 128'h00000003_00000002_00000001_00000000);
    wb_check("one_sent", 32'h14, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
